// File: rtl/stop_watch_pkg.sv
// Shared types and defaults for the stopwatch run/pause/lap/clear controller.
//   sw_state_e    : controller state encoding (2-bit)
//   DEB_DIV_W_DEF : default width of the debounce sample divider
//   TIME_W_DEF    : default width of the 4-digit BCD time bus
package stop_watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam int unsigned DEB_DIV_W_DEF = 17;
  localparam int unsigned TIME_W_DEF    = 16;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, sampling on a shared divider
// tick, level accepted only when two consecutive samples agree, and a
// one-clock pulse on the rising edge of the debounced level.
//   clk, reset_n : clock, asynchronous active-low reset
//   tick_i       : one-cycle sample strobe from the shared divider
//   btn_i        : raw asynchronous active-high button
//   press_o      : one-cycle pulse per debounced press (release is silent)
module btn_debounce (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q, sync2_q;
  logic samp_q;
  logic level_q, level_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      samp_q      <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      if (tick_i) begin
        samp_q <= sync2_q;
        // Previous sample vs current sample: both must agree to move the level.
        if (sync2_q == samp_q) level_q <= sync2_q;
      end
    end
  end

  assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch controller: debounces start/stop and lap/clear buttons, runs the
// IDLE/RUN/PAUSE/LAP state machine, drives counter enable/clear and selects
// the value shown on the 4-digit display (live time or lap snapshot).
// Optional feature macro: STOPWATCH_LAP_EN (LAP state + lap snapshot register).
//   clk, reset_n : clock, asynchronous active-low reset
//   btn_start    : raw start/stop button      btn_lap : raw lap/clear button
//   time_in      : live BCD time              disp_value : value to display
//   cnt_en       : counter enable             cnt_clr    : 1-cycle counter clear
//   run_led      : high while counting
module stop_watch_ctrl
  import stop_watch_pkg::*;
#(
  parameter int unsigned DEB_DIV_W = DEB_DIV_W_DEF,
  parameter int unsigned TIME_W    = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_start,
  input  logic              btn_lap,
  input  logic [TIME_W-1:0] time_in,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic [TIME_W-1:0] disp_value,
  output logic              run_led
);

  logic [DEB_DIV_W-1:0] div_q;
  logic                 tick;
  logic                 start_p, lap_p;
  sw_state_e            state_q, state_d;
  logic                 cnt_en_q, cnt_clr_q, clr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_q + 1'b1;
  end

  assign tick = (div_q == '1);

  btn_debounce u_deb_start (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_i  (tick),
    .btn_i   (btn_start),
    .press_o (start_p)
  );

  btn_debounce u_deb_lap (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_i  (tick),
    .btn_i   (btn_lap),
    .press_o (lap_p)
  );

`ifdef STOPWATCH_LAP_EN
  logic              lap_cap;
  logic              lap_sel_q;
  logic [TIME_W-1:0] lap_q;
`endif

  // start_p is tested first in every state, so a coincident lap_p is dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_cap = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start_p)    state_d = ST_RUN;
        else if (lap_p) clr_d   = 1'b1;
      end
      ST_RUN: begin
        if (start_p) state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_p) begin
          state_d = ST_LAP;
          lap_cap = 1'b1;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (start_p)    state_d = ST_PAUSE;
        else if (lap_p) lap_cap = 1'b1;
      end
`endif
      ST_PAUSE: begin
        if (start_p) state_d = ST_RUN;
        else if (lap_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= (state_d == ST_RUN) || (state_d == ST_LAP);
      cnt_clr_q <= clr_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_q     <= '0;
      lap_sel_q <= 1'b0;
    end else begin
      if (lap_cap) lap_q <= time_in;
      lap_sel_q <= (state_d == ST_LAP);
    end
  end

  assign disp_value = lap_sel_q ? lap_q : time_in;
`else
  assign disp_value = time_in;
`endif

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign run_led = cnt_en_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
module tb_stop_watch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_start, btn_lap;
  logic [15:0] time_in;
  logic        cnt_en, cnt_clr, run_led;
  logic [15:0] disp_value;

  int checks   = 0;
  int failures = 0;
  int clr_cnt  = 0;
  int en_rise  = 0;
  int overlap  = 0;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;

  stop_watch_ctrl #(.DEB_DIV_W(2), .TIME_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .time_in    (time_in),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .disp_value (disp_value),
    .run_led    (run_led)
  );

  always @(negedge clk) begin
    if (cnt_clr === 1'b1) clr_cnt++;
    if (cnt_clr === 1'b1 && cnt_en === 1'b1) overlap++;
    if (cnt_en === 1'b1 && en_prev === 1'b0) en_rise++;
    en_prev = cnt_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bounced press: 3 bounce cycles, steady hold, 3 bounce cycles, then settle.
  task automatic press(input logic s, input logic l, input int hold_ticks);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      btn_start = s & (i != 1);
      btn_lap   = l & (i != 1);
    end
    repeat (hold_ticks * 4) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      btn_start = s & (i == 1);
      btn_lap   = l & (i == 1);
    end
    #0;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    repeat (24) @(posedge clk);
  endtask

  typedef struct {
    logic        ps;
    logic        pl;
    logic [15:0] tin;
    logic [15:0] tin_after;
    logic        exp_en;
    int          exp_clr;
    logic [15:0] exp_disp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0001, 1'b1, 0, 16'h0001}; // IDLE->RUN
`ifdef STOPWATCH_LAP_EN
    tbl[1]  = '{1'b0, 1'b1, 16'h0042, 16'h0050, 1'b1, 0, 16'h0042}; // RUN->LAP snapshot
    tbl[2]  = '{1'b0, 1'b1, 16'h0107, 16'h0110, 1'b1, 0, 16'h0107}; // new split
`else
    tbl[1]  = '{1'b0, 1'b1, 16'h0042, 16'h0050, 1'b1, 0, 16'h0050}; // lap ignored
    tbl[2]  = '{1'b0, 1'b1, 16'h0107, 16'h0110, 1'b1, 0, 16'h0110};
`endif
    tbl[3]  = '{1'b1, 1'b0, 16'h0200, 16'h0201, 1'b0, 0, 16'h0201}; // ->PAUSE, live
    tbl[4]  = '{1'b0, 1'b1, 16'h0201, 16'h0000, 1'b0, 1, 16'h0000}; // PAUSE->IDLE clr
    tbl[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1, 16'h0000}; // IDLE lap clr
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0003, 1'b1, 0, 16'h0003}; // ->RUN
    tbl[7]  = '{1'b1, 1'b1, 16'h0305, 16'h0310, 1'b0, 0, 16'h0310}; // both in RUN -> PAUSE
    tbl[8]  = '{1'b1, 1'b1, 16'h0310, 16'h0311, 1'b1, 0, 16'h0311}; // both in PAUSE -> RUN
    tbl[9]  = '{1'b1, 1'b0, 16'h0400, 16'h0401, 1'b0, 0, 16'h0401}; // ->PAUSE
    tbl[10] = '{1'b0, 1'b1, 16'h0401, 16'h0000, 1'b0, 1, 16'h0000}; // ->IDLE clr

    reset_n   = 1'b0;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    time_in   = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_cnt_en",  {31'd0, cnt_en},  32'd0);
    chk("rst_cnt_clr", {31'd0, cnt_clr}, 32'd0);
    chk("rst_run_led", {31'd0, run_led}, 32'd0);
    chk("rst_disp",    {16'd0, disp_value}, 32'h1234);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      int clr0;
      string tag;
      tag = $sformatf("v%0d", i);
      time_in = tbl[i].tin;
      clr0 = clr_cnt;
      press(tbl[i].ps, tbl[i].pl, 6);
      #1;
      time_in = tbl[i].tin_after;
      repeat (2) @(negedge clk);
      chk({tag, "_cnt_en"},  {31'd0, cnt_en},  {31'd0, tbl[i].exp_en});
      chk({tag, "_run_led"}, {31'd0, run_led}, {31'd0, tbl[i].exp_en});
      chk({tag, "_disp"},    {16'd0, disp_value}, {16'd0, tbl[i].exp_disp});
      chk({tag, "_clr_cycles"}, clr_cnt - clr0, tbl[i].exp_clr);
    end

    // Long hold from IDLE: one pulse only, cnt_en one clock after the pulse.
    begin
      int rise0;
      bit seen;
      rise0 = en_rise;
      seen = 1'b0;
      time_in = 16'h0500;
      fork
        press(1'b1, 1'b0, 20);
        begin
          for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (dut.start_p === 1'b1) seen = 1'b1;
          end
          chk("hold_pulse_seen", {31'd0, seen}, 32'd1);
          chk("hold_en_at_pulse", {31'd0, cnt_en}, 32'd0);
          @(negedge clk);
          chk("hold_en_next_clk", {31'd0, cnt_en}, 32'd1);
        end
      join
      @(negedge clk);
      chk("hold_en_rises", en_rise - rise0, 32'd1);
      chk("hold_still_run", {31'd0, cnt_en}, 32'd1);
    end

    // Asynchronous reset while running.
    begin
      int clr0;
      clr0 = clr_cnt;
      time_in = 16'h0777;
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_cnt_en",  {31'd0, cnt_en},  32'd0);
      chk("mid_rst_cnt_clr", {31'd0, cnt_clr}, 32'd0);
      chk("mid_rst_run_led", {31'd0, run_led}, 32'd0);
      chk("mid_rst_disp",    {16'd0, disp_value}, 32'h0777);
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_idle", {31'd0, cnt_en}, 32'd0);
      chk("post_rst_no_clr", clr_cnt - clr0, 32'd0);
    end

    chk("clr_en_overlap", overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
